// File: rtl/master_port_burst.sv
// ADS bus master port with multi-beat bursts, per-beat memory-address increment and ack timeout.
// Define MASTER_PORT_RETRY_EN to retry a timed-out beat up to MAX_RETRY times before aborting.
module master_port_burst #(
   parameter int ADDR_WIDTH           = 16,
   parameter int DATA_WIDTH           = 8,
   parameter int SLAVE_MEM_ADDR_WIDTH = 12,
   parameter int MAX_BURST            = 16,
   parameter int TIMEOUT              = 5,
   parameter int MAX_RETRY            = 2,
   localparam int LW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] dwdata,
   input  logic [ADDR_WIDTH-1:0] daddr,
   input  logic                  dmode,
   input  logic [LW-1:0]         dlen,
   input  logic                  dvalid,
   output logic                  dready,
   output logic                  dwnext,
   output logic [DATA_WIDTH-1:0] drdata,
   output logic                  drvalid,
   output logic                  ddone,
   output logic                  derr,
   input  logic                  mrdata,
   input  logic                  svalid,
   output logic                  mwdata,
   output logic                  mvalid,
   output logic                  mmode,
   output logic                  mbreq,
   input  logic                  mbgrant,
   input  logic                  msplit,
   input  logic                  ack
);

   localparam int SMW  = SLAVE_MEM_ADDR_WIDTH;
   localparam int DW   = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
   localparam int BMAX = (DW > SMW) ? ((DW > DATA_WIDTH) ? DW : DATA_WIDTH)
                                    : ((SMW > DATA_WIDTH) ? SMW : DATA_WIDTH);
   localparam int CW   = $clog2(BMAX + 1);
   localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

`ifdef MASTER_PORT_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_REQ, S_SADDR, S_WAIT, S_ADDR, S_WDATA,
      S_RDATA, S_SPLIT, S_NEXT, S_RETRY, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  mode_q, mode_d;
   logic [LW-1:0]         len_q, len_d;
   logic [LW-1:0]         beat_q, beat_d;
   logic [RW-1:0]         retry_q, retry_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic [CW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
   logic                  abort_q, abort_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         mode_q   <= 1'b0;
         len_q    <= '0;
         beat_q   <= '0;
         retry_q  <= '0;
         tcnt_q   <= '0;
         bit_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         drdata_q <= '0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         mode_q   <= mode_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         retry_q  <= retry_d;
         tcnt_q   <= tcnt_d;
         bit_q    <= bit_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         drdata_q <= drdata_d;
         abort_q  <= abort_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      mode_d   = mode_q;
      len_d    = len_q;
      beat_d   = beat_q;
      retry_d  = retry_q;
      tcnt_d   = tcnt_q;
      bit_d    = bit_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      drdata_d = drdata_q;
      abort_d  = abort_q;
      mwdata   = 1'b0;
      mvalid   = 1'b0;
      dwnext   = 1'b0;
      drvalid  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (dvalid) begin
               addr_d  = daddr;
               mode_d  = dmode;
               len_d   = dlen;
               wdata_d = dwdata;
               beat_d  = '0;
               retry_d = '0;
               abort_d = 1'b0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mbgrant) begin
               bit_d   = '0;
               state_d = S_SADDR;
            end
         end
         S_SADDR: begin
            mvalid = 1'b1;
            mwdata = |(addr_q[ADDR_WIDTH-1:SMW] & (DW'(1) << bit_q));
            if (bit_q == CW'(DW - 1)) begin
               bit_d   = '0;
               tcnt_d  = '0;
               state_d = S_WAIT;
            end else begin
               bit_d = bit_q + CW'(1);
            end
         end
         S_WAIT: begin
            // ack has priority over a timeout landing in the same cycle
            if (ack) begin
               bit_d   = '0;
               state_d = S_ADDR;
            end else if (tcnt_q == TW'(TIMEOUT)) begin
               if (RETRY_EN && (retry_q < RW'(MAX_RETRY))) begin
                  retry_d = retry_q + RW'(1);
                  state_d = S_RETRY;
               end else begin
                  abort_d = 1'b1;
                  state_d = S_DONE;
               end
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         S_ADDR: begin
            mvalid = 1'b1;
            mwdata = |(addr_q[SMW-1:0] & (SMW'(1) << bit_q));
            if (bit_q == CW'(SMW - 1)) begin
               bit_d   = '0;
               rdata_d = '0;
               state_d = mode_q ? S_WDATA : S_RDATA;
            end else begin
               bit_d = bit_q + CW'(1);
            end
         end
         S_WDATA: begin
            // bit_q==0 is the idle setup cycle; data bit n goes out at bit_q==n+1
            if (bit_q != '0) begin
               mvalid = 1'b1;
               mwdata = |(wdata_q & (DATA_WIDTH'(1) << (bit_q - CW'(1))));
            end
            if (bit_q == CW'(DATA_WIDTH)) begin
               state_d = S_NEXT;
            end else begin
               bit_d = bit_q + CW'(1);
            end
         end
         S_RDATA: begin
            if (svalid) begin
               rdata_d = rdata_q | (DATA_WIDTH'(mrdata) << bit_q);
               bit_d   = bit_q + CW'(1);
            end
            if (svalid && (bit_q == CW'(DATA_WIDTH - 1))) begin
               drdata_d = rdata_d;
               state_d  = S_NEXT;
            end else if (msplit) begin
               state_d = S_SPLIT;
            end
         end
         S_SPLIT: begin
            if (!msplit && mbgrant) begin
               state_d = S_RDATA;
            end
         end
         S_NEXT: begin
            drvalid = !mode_q;
            if (beat_q != len_q) begin
               addr_d[SMW-1:0] = addr_q[SMW-1:0] + SMW'(1);
               beat_d          = beat_q + LW'(1);
               bit_d           = '0;
               if (mode_q) begin
                  dwnext  = 1'b1;
                  wdata_d = dwdata;
               end
               state_d = S_SADDR;
            end else begin
               state_d = S_DONE;
            end
         end
         S_RETRY: state_d = S_REQ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign dready = (state_q == S_IDLE);
   assign mbreq  = (state_q != S_IDLE) && (state_q != S_RETRY) && (state_q != S_DONE);
   assign ddone  = (state_q == S_DONE);
   assign derr   = (state_q == S_DONE) && abort_q;
   assign mmode  = mode_q;
   assign drdata = drdata_q;

endmodule
